// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Purpose  : Shares the single-port data RAM between the CPU memory stage
//             and the video burst read engine, steering read data back.
//  Revision : 1.0
// ============================================================================
module dmem_port_arbiter #(
    parameter int DATA_W       = 18,
    parameter int ADDR_W       = 10,
    parameter int BURST_MAX    = 16,
    parameter int STARVE_LIMIT = 4,
    localparam int LEN_W       = $clog2(BURST_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [LEN_W-1:0]  vid_len,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    output logic              vid_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int ST_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);
    localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(BURST_MAX);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_VID = 2'd2} owner_t;

    state_t              state_q, state_d;
    owner_t              rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0]   baddr_q, baddr_d;
    logic [LEN_W-1:0]    bcnt_q, bcnt_d;
    logic [ST_W-1:0]     cpu_starve_q, cpu_starve_d;
    logic [ST_W-1:0]     vid_starve_q, vid_starve_d;
    logic                last_q, last_d;
    logic                zdone_q, zdone_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;

    logic                w_stall, w_ack, w_en, w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [LEN_W-1:0]    w_len_eff;
    logic                w_cpu_rvalid, w_vid_rvalid, w_vid_done;

    always_comb begin
        state_d      = state_q;
        baddr_d      = baddr_q;
        bcnt_d       = bcnt_q;
        cpu_starve_d = cpu_starve_q;
        vid_starve_d = vid_starve_q;
        rd_owner_d   = OWN_NONE;
        last_d       = 1'b0;
        zdone_d      = 1'b0;
        w_stall      = 1'b0;
        w_ack        = 1'b0;
        w_en         = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        w_len_eff    = (vid_len > LEN_MAX) ? LEN_MAX : vid_len;

        case (state_q)
            S_IDLE: begin
                if (vid_req && (!cpu_req || vid_starve_q == STARVE_MAX)) begin
                    w_ack        = 1'b1;
                    w_stall      = cpu_req;
                    vid_starve_d = '0;
                    if (w_len_eff == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        baddr_d = vid_addr;
                        bcnt_d  = w_len_eff;
                        state_d = S_BURST;
                    end
                end else if (cpu_req) begin
                    w_en         = 1'b1;
                    w_we         = cpu_we;
                    w_addr       = cpu_addr;
                    w_wdata      = cpu_wdata;
                    rd_owner_d   = cpu_we ? OWN_NONE : OWN_CPU;
                    cpu_starve_d = '0;
                    // Reaching the limit makes video win next cycle, so no explicit saturation needed
                    if (vid_req) begin
                        vid_starve_d = vid_starve_q + 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (cpu_req && cpu_starve_q == STARVE_MAX) begin
                    // Forced CPU slot: the pending beat waits, address and count unchanged
                    w_en         = 1'b1;
                    w_we         = cpu_we;
                    w_addr       = cpu_addr;
                    w_wdata      = cpu_wdata;
                    rd_owner_d   = cpu_we ? OWN_NONE : OWN_CPU;
                    cpu_starve_d = '0;
                end else begin
                    w_en       = 1'b1;
                    w_addr     = baddr_q;
                    rd_owner_d = OWN_VID;
                    last_d     = (bcnt_q == LEN_W'(1));
                    baddr_d    = baddr_q + 1'b1;
                    bcnt_d     = bcnt_q - 1'b1;
                    if (bcnt_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                    end
                    if (cpu_req) begin
                        w_stall      = 1'b1;
                        cpu_starve_d = cpu_starve_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign w_vid_rvalid = (rd_owner_q == OWN_VID);
    assign w_vid_done   = (w_vid_rvalid && last_q) || zdone_q;
    assign cpu_rdata_d  = w_cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign vid_rdata_d  = w_vid_rvalid ? mem_rdata : vid_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rd_owner_q   <= OWN_NONE;
            baddr_q      <= '0;
            bcnt_q       <= '0;
            cpu_starve_q <= '0;
            vid_starve_q <= '0;
            last_q       <= 1'b0;
            zdone_q      <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            rd_owner_q   <= rd_owner_d;
            baddr_q      <= baddr_d;
            bcnt_q       <= bcnt_d;
            cpu_starve_q <= cpu_starve_d;
            vid_starve_q <= vid_starve_d;
            last_q       <= last_d;
            zdone_q      <= zdone_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rdata_q  <= vid_rdata_d;
        end
    end

    // Outputs are forced low while reset is held, combinational paths included
    assign cpu_stall  = rst & w_stall;
    assign cpu_rvalid = rst & w_cpu_rvalid;
    assign cpu_rdata  = rst ? cpu_rdata_d : '0;
    assign vid_ack    = rst & w_ack;
    assign vid_rvalid = rst & w_vid_rvalid;
    assign vid_rdata  = rst ? vid_rdata_d : '0;
    assign vid_done   = rst & w_vid_done;
    assign mem_en     = rst & w_en;
    assign mem_we     = rst & w_we;
    assign mem_addr   = rst ? w_addr : '0;
    assign mem_wdata  = rst ? w_wdata : '0;

endmodule
`default_nettype wire
